// File: rtl/design_1_clkgen.sv
// design_1_clkgen: clock-wizard stand-in producing a buffered clk_0 copy, a clk_0/DIV clock,
// and a lock flag sequenced behind a synchronized release of the async active-low reset.
module design_1_clkgen #(
    parameter int DIV         = 10,
    parameter int LOCK_CYCLES = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_0,
    input  logic rst_0,
    output logic clk_100Mhz,
    output logic clk_10Mhz,
    output logic locked_0
);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int DW = $clog2(DIV / 2 + 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(DIV / 2 - 1);

    generate
        if (DIV < 2 || DIV % 2 != 0 || LOCK_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
            $error("design_1_clkgen: DIV must be even and >=2, LOCK_CYCLES >=1, SYNC_STAGES >=2");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync;
    logic                   rst_sync;
    logic [LW-1:0]          lock_cnt;
    logic [DW-1:0]          div_cnt;
    logic                   div_wrap;

    assign clk_100Mhz = clk_0;
    assign rst_sync   = sync[SYNC_STAGES-1];
    assign div_wrap   = div_cnt == DIV_LAST;

    // assertion is asynchronous, release ripples through the chain
    always_ff @(posedge clk_0 or negedge rst_0)
        if (!rst_0) sync <= '0;
        else sync <= {sync[SYNC_STAGES-2:0], 1'b1};

    always_ff @(posedge clk_0 or negedge rst_0)
        if (!rst_0) begin
            lock_cnt <= '0;
            locked_0 <= 1'b0;
        end else if (rst_sync && !locked_0) begin
            lock_cnt <= lock_cnt + 1'b1;
            locked_0 <= lock_cnt == LOCK_LAST;
        end

    always_ff @(posedge clk_0 or negedge rst_0)
        if (!rst_0) begin
            div_cnt   <= '0;
            clk_10Mhz <= 1'b0;
        end else if (!locked_0) begin
            div_cnt   <= '0;
            clk_10Mhz <= 1'b0;
        end else begin
            div_cnt   <= div_wrap ? '0 : div_cnt + 1'b1;
            clk_10Mhz <= clk_10Mhz ^ div_wrap;
        end
endmodule

// File: tb/tb_design_1_clkgen.sv
// tb_design_1_clkgen: randomized reset timing checked against timing expectations derived from the parameters.
`timescale 1ns/100ps
module tb_design_1_clkgen;
    localparam int DIV = 10, LC = 64, SS = 2, T = 10;
    localparam int LOCK_EDGES = SS + LC;

    logic clk_0 = 1'b0, rst_0 = 1'b0;
    logic clk_100Mhz, clk_10Mhz, locked_0;
    int checks = 0, errors = 0;

    design_1_clkgen #(.DIV(DIV), .LOCK_CYCLES(LC), .SYNC_STAGES(SS)) dut (
        .clk_0(clk_0), .rst_0(rst_0), .clk_100Mhz(clk_100Mhz),
        .clk_10Mhz(clk_10Mhz), .locked_0(locked_0));

    always #(T/2) clk_0 = ~clk_0;

    // counts clk_0 rising edges until locked_0 is seen; outputs must be clean zeros before that
    task automatic wait_lock(output int n, output int bad);
        n = 0; bad = 0;
        do begin
            @(posedge clk_0); #1; n++;
            if (locked_0 !== 1'b1 && (locked_0 !== 1'b0 || clk_10Mhz !== 1'b0)) bad++;
        end while (locked_0 !== 1'b1 && n < 500);
    endtask

    task automatic check_lock(string name, int n, int bad);
        checks++;
        if (n != LOCK_EDGES) begin errors++; $display("FAIL %s lock_edges got %0d want %0d", name, n, LOCK_EDGES); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL %s outputs_during_lockup bad_samples %0d want 0", name, bad); end
    endtask

    task automatic release_and_lock(string name);
        int n, bad;
        @(posedge clk_0); #($urandom_range(1, 8)); rst_0 = 1'b1;
        wait_lock(n, bad);
        check_lock(name, n, bad);
    endtask

    task automatic test_reset();
        int n, bad = 0;
        rst_0 = 1'b0;
        repeat (49) begin
            #1;
            if (locked_0 !== 1'b0 || clk_10Mhz !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_hold bad_samples %0d want 0", bad); end
        #1 rst_0 = 1'b1;
        wait_lock(n, bad);
        check_lock("powerup", n, bad);
    endtask

    task automatic test_phase(string name);
        int n = 0;
        do begin @(posedge clk_0); #1; n++; end while (clk_10Mhz !== 1'b1 && n < 100);
        checks++;
        if (n != DIV / 2) begin errors++; $display("FAIL %s phase_edges got %0d want %0d", name, n, DIV / 2); end
    endtask

    task automatic test_frequency();
        time t_rise = 0;
        int nper = 0, per_bad = 0, hi_bad = 0, guard = 0, buf_bad = 0;
        logic prev = clk_10Mhz;
        while (nper < 21 && guard < 1000) begin
            @(posedge clk_0); #1; guard++;
            if (!prev && clk_10Mhz) begin
                if (nper > 0 && ($time - t_rise) != DIV * T) per_bad++;
                t_rise = $time; nper++;
            end
            if (prev && !clk_10Mhz && nper > 0 && ($time - t_rise) != DIV / 2 * T) hi_bad++;
            prev = clk_10Mhz;
        end
        checks++;
        if (nper != 21) begin errors++; $display("FAIL freq_rises got %0d want 21", nper); end
        checks++;
        if (per_bad != 0) begin errors++; $display("FAIL freq_period bad %0d want 0", per_bad); end
        checks++;
        if (hi_bad != 0) begin errors++; $display("FAIL freq_high bad %0d want 0", hi_bad); end
        repeat (20) begin
            #($urandom_range(1, 9));
            if (clk_100Mhz !== clk_0) buf_bad++;
        end
        checks++;
        if (buf_bad != 0) begin errors++; $display("FAIL clk_100Mhz_follow bad %0d want 0", buf_bad); end
    endtask

    task automatic test_mid_reset(int k);
        int g = 0, bad = 0;
        while (clk_10Mhz !== 1'b1 && g < 100) begin @(posedge clk_0); #1; g++; end
        #($urandom_range(0, 8));
        checks++;
        if (clk_10Mhz !== 1'b1) begin errors++; $display("FAIL mid_reset%0d pre_clk10 got %b want 1", k, clk_10Mhz); end
        rst_0 = 1'b0;
        #0.1;
        checks++;
        if (clk_10Mhz !== 1'b0 || locked_0 !== 1'b0)
            begin errors++; $display("FAIL mid_reset%0d immediate got clk10=%b locked=%b want 0 0", k, clk_10Mhz, locked_0); end
        repeat ($urandom_range(1, 30)) begin
            @(posedge clk_0); #1;
            if (clk_100Mhz !== 1'b1 || clk_10Mhz !== 1'b0 || locked_0 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_reset%0d hold bad_samples %0d want 0", k, bad); end
        release_and_lock($sformatf("mid_reset%0d", k));
    endtask

    task automatic test_glitch(int k);
        int n, bad;
        @(posedge clk_0); #($urandom_range(1, 5));
        rst_0 = 1'b0;
        #($urandom_range(1, 3));
        rst_0 = 1'b1;
        #0.1;
        checks++;
        if (clk_10Mhz !== 1'b0 || locked_0 !== 1'b0)
            begin errors++; $display("FAIL glitch%0d cleared got clk10=%b locked=%b want 0 0", k, clk_10Mhz, locked_0); end
        wait_lock(n, bad);
        check_lock($sformatf("glitch%0d", k), n, bad);
    endtask

    task automatic test_held();
        int bad = 0;
        @(posedge clk_0); #1; rst_0 = 1'b0;
        repeat (400) begin
            #5;
            if (locked_0 !== 1'b0 || clk_10Mhz !== 1'b0 || clk_100Mhz !== clk_0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL held_reset bad_samples %0d want 0", bad); end
        release_and_lock("held");
    endtask

    initial begin
        test_reset();
        test_phase("powerup");
        test_frequency();
        for (int k = 0; k < 4; k++) begin
            test_mid_reset(k);
            test_phase($sformatf("mid_reset%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            test_glitch(k);
            test_phase($sformatf("glitch%0d", k));
        end
        test_held();
        test_phase("held");
        test_frequency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
